// File: rtl/lsu_ctrl_mo_pkg.sv
// Shared types and constants for the multi-outstanding LSU control unit.
// Access-size encodings, tag-entry layout and default widths.
package lsu_ctrl_mo_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 16;
    localparam int TW_DEF   = 4;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    // Non-tag bits of a tag-FIFO entry: {read, size[1:0], usign, addr[1:0]}
    localparam int LSU_ENT_XW = 6;

endpackage

// File: rtl/lsu_ctrl_mo_if.sv
// Bundle of AGU, DTCM and writeback channels around the LSU.
// master = the LSU itself, slave = the surrounding pipeline/memory.
interface lsu_ctrl_mo_if #(
    parameter int XLEN = 32,
    parameter int AW   = 16,
    parameter int TW   = 4
);
    logic              agu_cmd_valid;
    logic              agu_cmd_ready;
    logic              agu_cmd_read;
    logic [AW-1:0]     agu_cmd_addr;
    logic [XLEN-1:0]   agu_cmd_wdata;
    logic [XLEN/8-1:0] agu_cmd_wmask;
    logic [1:0]        agu_cmd_size;
    logic              agu_cmd_usign;
    logic [TW-1:0]     agu_cmd_itag;
    logic              agu_rsp_valid;

    logic              dtcm_cmd_valid;
    logic              dtcm_cmd_ready;
    logic              dtcm_cmd_read;
    logic [AW-1:0]     dtcm_cmd_addr;
    logic [XLEN-1:0]   dtcm_cmd_wdata;
    logic [XLEN/8-1:0] dtcm_cmd_wmask;
    logic              dtcm_rsp_valid;
    logic              dtcm_rsp_ready;
    logic [XLEN-1:0]   dtcm_rsp_rdata;

    logic              lsu_o_valid;
    logic              lsu_o_ready;
    logic [XLEN-1:0]   lsu_o_wbck_data;
    logic [TW-1:0]     lsu_o_wbck_itag;
    logic              lsu_idle;

    modport master (
        input  agu_cmd_valid, agu_cmd_read, agu_cmd_addr,
        input  agu_cmd_wdata, agu_cmd_wmask, agu_cmd_size,
        input  agu_cmd_usign, agu_cmd_itag,
        output agu_cmd_ready, agu_rsp_valid,
        output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr,
        output dtcm_cmd_wdata, dtcm_cmd_wmask, dtcm_rsp_ready,
        input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata,
        output lsu_o_valid, lsu_o_wbck_data, lsu_o_wbck_itag,
        output lsu_idle,
        input  lsu_o_ready
    );

    modport slave (
        output agu_cmd_valid, agu_cmd_read, agu_cmd_addr,
        output agu_cmd_wdata, agu_cmd_wmask, agu_cmd_size,
        output agu_cmd_usign, agu_cmd_itag,
        input  agu_cmd_ready, agu_rsp_valid,
        input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr,
        input  dtcm_cmd_wdata, dtcm_cmd_wmask, dtcm_rsp_ready,
        output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata,
        input  lsu_o_valid, lsu_o_wbck_data, lsu_o_wbck_itag,
        input  lsu_idle,
        output lsu_o_ready
    );

endinterface

// File: rtl/lsu_ctrl_mo_gnrl_fifo.sv
// Generic valid/ready FIFO, DW bits wide and DP entries deep.
// Push is refused when full even if a pop happens in the same cycle.
module gnrl_fifo #(
    parameter int DW = 8,
    parameter int DP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld_i,
    output logic          push_rdy_o,
    input  logic [DW-1:0] push_dat_i,
    output logic          pop_vld_o,
    input  logic          pop_rdy_i,
    output logic [DW-1:0] pop_dat_o
);
    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [DW-1:0] mem_q [DP];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    assign push_rdy_o = (cnt_q != CW'(DP));
    assign pop_vld_o  = (cnt_q != '0);
    assign pop_dat_o  = mem_q[rptr_q];
    assign push       = push_vld_i & push_rdy_o;
    assign pop        = pop_vld_o & pop_rdy_i;

    // Pointer wrap and occupancy next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = (wptr_q == PW'(DP - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PW'(DP - 1)) ? '0 : rptr_q + PW'(1);
        end
        unique case (1'b1)
            (push & ~pop): cnt_d = cnt_q + CW'(1);
            (pop & ~push): cnt_d = cnt_q - CW'(1);
            default:       cnt_d = cnt_q;
        endcase
    end

    // Pointer, counter and storage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DP; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/lsu_ctrl_mo.sv
// Multi-outstanding LSU: AGU -> DTCM issue, in-order tag tracking,
// load alignment/extension and a registered writeback slot.
module lsu_ctrl_mo
    import lsu_ctrl_mo_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int AW         = AW_DEF,
    parameter int TW         = TW_DEF,
    parameter int OUTS_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    lsu_ctrl_mo_if.master bus
);
    localparam int EW = TW + LSU_ENT_XW;

    logic          fifo_push_rdy;
    logic          fifo_pop_vld;
    logic          fifo_pop_rdy;
    logic [EW-1:0] push_ent;
    logic [EW-1:0] head;

    logic [TW-1:0] head_itag;
    logic          head_read;
    logic [1:0]    head_size;
    logic          head_usign;
    logic [1:0]    head_addr;

    logic          pop, load_pop;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [XLEN-1:0] ld_ext;

    logic            wb_vld_q, wb_vld_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [TW-1:0]   wb_itag_q, wb_itag_d;

    assign push_ent = {bus.agu_cmd_itag, bus.agu_cmd_read,
                       bus.agu_cmd_size, bus.agu_cmd_usign,
                       bus.agu_cmd_addr[1:0]};

    gnrl_fifo #(
        .DW (EW),
        .DP (OUTS_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (bus.agu_cmd_valid & bus.dtcm_cmd_ready),
        .push_rdy_o (fifo_push_rdy),
        .push_dat_i (push_ent),
        .pop_vld_o  (fifo_pop_vld),
        .pop_rdy_i  (fifo_pop_rdy),
        .pop_dat_o  (head)
    );

    assign head_itag  = head[EW-1:LSU_ENT_XW];
    assign head_read  = head[5];
    assign head_size  = head[4:3];
    assign head_usign = head[2];
    assign head_addr  = head[1:0];

    assign bus.agu_cmd_ready  = bus.dtcm_cmd_ready & fifo_push_rdy;
    assign bus.dtcm_cmd_valid = bus.agu_cmd_valid & fifo_push_rdy;
    assign bus.dtcm_cmd_read  = bus.agu_cmd_read;
    assign bus.dtcm_cmd_addr  = bus.agu_cmd_addr;
    assign bus.dtcm_cmd_wdata = bus.agu_cmd_wdata;
    assign bus.dtcm_cmd_wmask = bus.agu_cmd_wmask;

    // A load may only retire when the slot is free or draining now
    assign bus.dtcm_rsp_ready = fifo_pop_vld &
        (~head_read | ~wb_vld_q | bus.lsu_o_ready);
    assign fifo_pop_rdy       = bus.dtcm_rsp_valid & bus.dtcm_rsp_ready;
    assign pop                = fifo_pop_vld & fifo_pop_rdy;
    assign load_pop           = pop & head_read;
    assign bus.agu_rsp_valid  = pop;

    // Lane select and sign/zero extension of the raw read word
    always_comb begin
        ld_byte = bus.dtcm_rsp_rdata[{head_addr, 3'b000} +: 8];
        ld_half = head_addr[1] ? bus.dtcm_rsp_rdata[31:16]
                               : bus.dtcm_rsp_rdata[15:0];
        ld_ext  = bus.dtcm_rsp_rdata;
        unique case (1'b1)
            (head_size == LSU_SIZE_B):
                ld_ext = {{(XLEN-8){ld_byte[7] & ~head_usign}}, ld_byte};
            (head_size == LSU_SIZE_H):
                ld_ext = {{(XLEN-16){ld_half[15] & ~head_usign}}, ld_half};
            default:
                ld_ext = bus.dtcm_rsp_rdata;
        endcase
    end

    // Writeback slot: load pop overwrites, consumer handshake clears
    always_comb begin
        wb_vld_d  = wb_vld_q;
        wb_data_d = wb_data_q;
        wb_itag_d = wb_itag_q;
        if (load_pop) begin
            wb_vld_d  = 1'b1;
            wb_data_d = ld_ext;
            wb_itag_d = head_itag;
        end else if (wb_vld_q & bus.lsu_o_ready) begin
            wb_vld_d  = 1'b0;
        end
    end

    // Writeback slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld_q  <= 1'b0;
            wb_data_q <= '0;
            wb_itag_q <= '0;
        end else begin
            wb_vld_q  <= wb_vld_d;
            wb_data_q <= wb_data_d;
            wb_itag_q <= wb_itag_d;
        end
    end

    assign bus.lsu_o_valid     = wb_vld_q;
    assign bus.lsu_o_wbck_data = wb_data_q;
    assign bus.lsu_o_wbck_itag = wb_itag_q;
    assign bus.lsu_idle        = ~fifo_pop_vld & ~wb_vld_q;

endmodule

// File: tb/tb_lsu_ctrl_mo.sv
// Directed bench for lsu_ctrl_mo with hand-computed expectations.
// OUTS_DEPTH=2; DTCM responses are driven step by step.
module tb_lsu_ctrl_mo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_ctrl_mo_if #(.XLEN(32), .AW(16), .TW(4)) bus ();

    lsu_ctrl_mo #(
        .XLEN       (32),
        .AW         (16),
        .TW         (4),
        .OUTS_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic rd, input logic [15:0] a,
                       input logic [1:0] sz, input logic us,
                       input logic [3:0] tg);
        bus.agu_cmd_valid = 1'b1;
        bus.agu_cmd_read  = rd;
        bus.agu_cmd_addr  = a;
        bus.agu_cmd_size  = sz;
        bus.agu_cmd_usign = us;
        bus.agu_cmd_itag  = tg;
        bus.agu_cmd_wmask = rd ? 4'h0 : 4'hF;
        bus.agu_cmd_wdata = rd ? 32'h0 : 32'hCAFE_F00D;
    endtask

    task automatic do_load(input string tag, input logic [15:0] a,
                           input logic [1:0] sz, input logic us,
                           input logic [3:0] tg, input logic [31:0] rd,
                           input logic [31:0] exp);
        cmd(1'b1, a, sz, us, tg);
        #1;
        chk({tag, "_cmd_rdy"}, bus.agu_cmd_ready, 1);
        tick();
        bus.agu_cmd_valid  = 1'b0;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = rd;
        #1;
        chk({tag, "_rsp_pulse"}, bus.agu_rsp_valid, 1);
        tick();
        bus.dtcm_rsp_valid = 1'b0;
        #1;
        chk({tag, "_o_valid"}, bus.lsu_o_valid, 1);
        chk({tag, "_data"}, bus.lsu_o_wbck_data, exp);
        chk({tag, "_itag"}, bus.lsu_o_wbck_itag, 32'(tg));
        tick();
        chk({tag, "_drained"}, bus.lsu_o_valid, 0);
    endtask

    initial begin
        bus.agu_cmd_valid  = 1'b0;
        bus.agu_cmd_read   = 1'b0;
        bus.agu_cmd_addr   = '0;
        bus.agu_cmd_wdata  = '0;
        bus.agu_cmd_wmask  = '0;
        bus.agu_cmd_size   = 2'b00;
        bus.agu_cmd_usign  = 1'b0;
        bus.agu_cmd_itag   = '0;
        bus.dtcm_cmd_ready = 1'b1;
        bus.dtcm_rsp_valid = 1'b0;
        bus.dtcm_rsp_rdata = '0;
        bus.lsu_o_ready    = 1'b1;

        // reset and idle, spurious response ignored
        tick();
        tick();
        chk("rst_idle", bus.lsu_idle, 1);
        chk("rst_o_valid", bus.lsu_o_valid, 0);
        chk("rst_rsp_ready", bus.dtcm_rsp_ready, 0);
        chk("rst_data", bus.lsu_o_wbck_data, 0);
        rst = 1'b0;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("spur_rsp_ready", bus.dtcm_rsp_ready, 0);
        chk("spur_agu_rsp", bus.agu_rsp_valid, 0);
        tick();
        chk("spur_idle", bus.lsu_idle, 1);
        chk("spur_o_valid", bus.lsu_o_valid, 0);
        bus.dtcm_rsp_valid = 1'b0;

        // command passthrough
        cmd(1'b1, 16'h1233, 2'b00, 1'b0, 4'd5);
        #1;
        chk("pass_valid", bus.dtcm_cmd_valid, 1);
        chk("pass_addr", bus.dtcm_cmd_addr, 32'h1233);
        chk("pass_read", bus.dtcm_cmd_read, 1);
        bus.agu_cmd_valid = 1'b0;
        #1;
        chk("pass_novalid", bus.dtcm_cmd_valid, 0);

        // load extraction
        do_load("lb_s", 16'h0003, 2'b00, 1'b0, 4'd5,
                32'h80FF_1234, 32'hFFFF_FF80);
        do_load("lbu", 16'h0003, 2'b00, 1'b1, 4'd6,
                32'h80FF_1234, 32'h0000_0080);
        do_load("lb_l1", 16'h0001, 2'b00, 1'b0, 4'd7,
                32'h0000_7F00, 32'h0000_007F);
        do_load("lh_s", 16'h0002, 2'b01, 1'b0, 4'd8,
                32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu0", 16'h0000, 2'b01, 1'b1, 4'd9,
                32'h1234_F00D, 32'h0000_F00D);
        do_load("lw", 16'h0004, 2'b10, 1'b0, 4'd10,
                32'h8765_4321, 32'h8765_4321);
        chk("after_loads_idle", bus.lsu_idle, 1);

        // back-to-back, third command held while full
        cmd(1'b1, 16'h0, 2'b10, 1'b0, 4'd1);
        tick();
        cmd(1'b1, 16'h4, 2'b10, 1'b0, 4'd2);
        #1;
        chk("b2b_rdy2", bus.agu_cmd_ready, 1);
        tick();
        cmd(1'b1, 16'h8, 2'b10, 1'b0, 4'd3);
        #1;
        chk("b2b_full_rdy", bus.agu_cmd_ready, 0);
        chk("b2b_full_dvld", bus.dtcm_cmd_valid, 0);
        tick();
        chk("b2b_full_hold", bus.agu_cmd_ready, 0);
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'h11;
        #1;
        chk("b2b_rsp1_rdy", bus.dtcm_rsp_ready, 1);
        chk("b2b_no_bypass", bus.agu_cmd_ready, 0);
        tick();
        bus.dtcm_rsp_rdata = 32'h22;
        #1;
        chk("b2b_push3_rdy", bus.agu_cmd_ready, 1);
        chk("b2b_wb1_itag", bus.lsu_o_wbck_itag, 1);
        chk("b2b_wb1_data", bus.lsu_o_wbck_data, 32'h11);
        tick();
        bus.agu_cmd_valid  = 1'b0;
        bus.dtcm_rsp_rdata = 32'h33;
        #1;
        chk("b2b_wb2_itag", bus.lsu_o_wbck_itag, 2);
        chk("b2b_wb2_data", bus.lsu_o_wbck_data, 32'h22);
        tick();
        bus.dtcm_rsp_valid = 1'b0;
        #1;
        chk("b2b_wb3_itag", bus.lsu_o_wbck_itag, 3);
        chk("b2b_wb3_data", bus.lsu_o_wbck_data, 32'h33);
        chk("b2b_wb3_vld", bus.lsu_o_valid, 1);
        tick();
        chk("b2b_idle", bus.lsu_idle, 1);

        // backpressure with a store retiring behind the blocked slot
        bus.lsu_o_ready = 1'b0;
        cmd(1'b1, 16'h0, 2'b10, 1'b0, 4'd7);
        tick();
        cmd(1'b0, 16'h20, 2'b10, 1'b0, 4'd9);
        #1;
        chk("st_cmd_read", bus.dtcm_cmd_read, 0);
        chk("st_cmd_wmask", bus.dtcm_cmd_wmask, 32'hF);
        chk("st_cmd_wdata", bus.dtcm_cmd_wdata, 32'hCAFE_F00D);
        tick();
        bus.agu_cmd_valid  = 1'b0;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'hAAAA_5555;
        tick();
        chk("bp_slotA_vld", bus.lsu_o_valid, 1);
        chk("bp_slotA_itag", bus.lsu_o_wbck_itag, 7);
        chk("bp_st_rdy", bus.dtcm_rsp_ready, 1);
        chk("bp_st_pulse", bus.agu_rsp_valid, 1);
        tick();
        bus.dtcm_rsp_valid = 1'b0;
        cmd(1'b1, 16'h0, 2'b10, 1'b0, 4'd8);
        tick();
        bus.agu_cmd_valid  = 1'b0;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'h0000_BBBB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_hold_rdy", bus.dtcm_rsp_ready, 0);
            chk("bp_hold_pulse", bus.agu_rsp_valid, 0);
            chk("bp_hold_itag", bus.lsu_o_wbck_itag, 7);
            chk("bp_hold_data", bus.lsu_o_wbck_data, 32'hAAAA_5555);
            tick();
        end
        bus.lsu_o_ready = 1'b1;
        #1;
        chk("bp_release_rdy", bus.dtcm_rsp_ready, 1);
        tick();
        bus.dtcm_rsp_valid = 1'b0;
        #1;
        chk("bp_ovw_vld", bus.lsu_o_valid, 1);
        chk("bp_ovw_itag", bus.lsu_o_wbck_itag, 8);
        chk("bp_ovw_data", bus.lsu_o_wbck_data, 32'h0000_BBBB);
        tick();
        chk("bp_idle", bus.lsu_idle, 1);

        // reset mid-operation
        bus.lsu_o_ready = 1'b0;
        cmd(1'b1, 16'h0, 2'b10, 1'b0, 4'd1);
        tick();
        cmd(1'b1, 16'h4, 2'b10, 1'b0, 4'd2);
        tick();
        bus.agu_cmd_valid  = 1'b0;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'h5A5A_5A5A;
        tick();
        bus.dtcm_rsp_valid = 1'b0;
        cmd(1'b1, 16'h8, 2'b10, 1'b0, 4'd3);
        tick();
        bus.agu_cmd_valid = 1'b0;
        #1;
        chk("mid_full", bus.agu_cmd_ready, 0);
        chk("mid_slot", bus.lsu_o_valid, 1);
        chk("mid_busy", bus.lsu_idle, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_o_valid", bus.lsu_o_valid, 0);
        chk("arst_data", bus.lsu_o_wbck_data, 0);
        chk("arst_itag", bus.lsu_o_wbck_itag, 0);
        chk("arst_idle", bus.lsu_idle, 1);
        chk("arst_rsp_rdy", bus.dtcm_rsp_ready, 0);
        chk("arst_cmd_rdy", bus.agu_cmd_ready, 1);
        tick();
        rst = 1'b0;
        bus.dtcm_rsp_valid = 1'b1;
        #1;
        chk("late_rsp_rdy", bus.dtcm_rsp_ready, 0);
        chk("late_rsp_pulse", bus.agu_rsp_valid, 0);
        tick();
        chk("late_o_valid", bus.lsu_o_valid, 0);
        chk("late_idle", bus.lsu_idle, 1);
        bus.dtcm_rsp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
